// File: rtl/if_pd_fifo.sv
// IF->PD decoupling FIFO: DEPTH-entry register queue with valid/ready on both sides.
// Payload is {pc, pc+8, bd, addr_error, meta}; in_ready depends only on registered state.
module if_pd_fifo #(
  parameter int DEPTH  = 2,
  parameter int META_W = 64,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_pc,
  input  logic              in_bd,
  input  logic              in_addr_error,
  input  logic [META_W-1:0] in_meta,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_pc,
  output logic [31:0]       out_pc_8,
  output logic              out_bd,
  output logic              out_addr_error,
  output logic [META_W-1:0] out_meta,
  output logic [CNT_W-1:0]  count
);

  typedef struct packed {
    logic [31:0]       pc;
    logic [31:0]       pc_8;
    logic              bd;
    logic              addr_error;
    logic [META_W-1:0] meta;
  } entry_t;

  entry_t           mem_q [DEPTH];
  entry_t           wr_entry;
  entry_t           head;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push, pop;

  assign in_ready  = (cnt_q != CNT_W'(DEPTH));
  assign out_valid = (cnt_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign count     = cnt_q;

  always_comb begin
    wr_entry            = '0;
    wr_entry.pc         = in_pc;
    wr_entry.pc_8       = in_pc + 32'd8;
    wr_entry.bd         = in_bd;
    wr_entry.addr_error = in_addr_error;
    wr_entry.meta       = in_meta;
  end

  // Flush overrides any simultaneous push/pop; pointers wrap naturally at PTR_W bits.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      cnt_d = cnt_q + CNT_W'(1);
      else if (pop && !push) cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push && !flush) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  // Payload outputs are gated to zero whenever the queue is empty.
  assign head           = mem_q[rd_ptr_q];
  assign out_pc         = out_valid ? head.pc         : '0;
  assign out_pc_8       = out_valid ? head.pc_8       : '0;
  assign out_bd         = out_valid ? head.bd         : 1'b0;
  assign out_addr_error = out_valid ? head.addr_error : 1'b0;
  assign out_meta       = out_valid ? head.meta       : '0;

endmodule

// File: tb/tb_if_pd_fifo.sv
// Directed bench for if_pd_fifo: DEPTH=2 instance for fill/stream/flush/reset,
// DEPTH=4 instance for pointer wrap against a queue scoreboard.
module tb_if_pd_fifo;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  // DEPTH=2 instance
  logic        flush, in_valid, in_ready, in_bd, in_ae, out_valid, out_ready;
  logic [31:0] in_pc, out_pc, out_pc_8;
  logic        out_bd, out_ae;
  logic [63:0] in_meta, out_meta;
  logic [1:0]  count;

  if_pd_fifo #(.DEPTH(2), .META_W(64)) dut2 (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_bd(in_bd),
    .in_addr_error(in_ae), .in_meta(in_meta),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_pc_8(out_pc_8),
    .out_bd(out_bd), .out_addr_error(out_ae), .out_meta(out_meta), .count(count)
  );

  // DEPTH=4 instance
  logic        flush4, in_valid4, in_ready4, in_bd4, in_ae4, out_valid4, out_ready4;
  logic [31:0] in_pc4, out_pc4, out_pc_84;
  logic        out_bd4, out_ae4;
  logic [7:0]  in_meta4, out_meta4;
  logic [2:0]  count4;

  if_pd_fifo #(.DEPTH(4), .META_W(8)) dut4 (
    .clk(clk), .resetn(resetn), .flush(flush4),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_pc(in_pc4), .in_bd(in_bd4),
    .in_addr_error(in_ae4), .in_meta(in_meta4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_pc(out_pc4), .out_pc_8(out_pc_84),
    .out_bd(out_bd4), .out_addr_error(out_ae4), .out_meta(out_meta4), .count(count4)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] q[$];
  logic [63:0] ptn;
  int          n_pushed;
  int          max_cnt;
  bit          exp_push, exp_pop;
  logic [31:0] pc_now;

  initial begin
    resetn = 1'b0; flush = 0; in_valid = 0; in_pc = 0; in_bd = 0; in_ae = 0;
    in_meta = 0; out_ready = 0;
    flush4 = 0; in_valid4 = 0; in_pc4 = 0; in_bd4 = 0; in_ae4 = 0; in_meta4 = 0;
    out_ready4 = 0;
    #3;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_out_pc", 64'(out_pc), 64'd0);
    step();
    resetn = 1'b1;
    step();

    // Fill to full with predecode stalled, then drain.
    in_valid = 1; in_pc = 32'h1000; in_meta = 64'h11;
    step();
    chk("fill1_count", 64'(count), 64'd1);
    chk("fill1_out_valid", 64'(out_valid), 64'd1);
    chk("fill1_out_pc", 64'(out_pc), 64'h1000);
    chk("fill1_out_pc_8", 64'(out_pc_8), 64'h1008);
    chk("fill1_meta", out_meta, 64'h11);
    in_pc = 32'h1004; in_meta = 64'h22;
    step();
    chk("fill2_count", 64'(count), 64'd2);
    chk("fill2_in_ready", 64'(in_ready), 64'd0);
    in_pc = 32'h1008;
    out_ready = 0;
    step();
    chk("full_reject_count", 64'(count), 64'd2);
    chk("full_hold_pc", 64'(out_pc), 64'h1000);
    chk("full_hold_valid", 64'(out_valid), 64'd1);
    in_valid = 0; out_ready = 1;
    step();
    chk("drain1_pc", 64'(out_pc), 64'h1004);
    chk("drain1_pc_8", 64'(out_pc_8), 64'h100C);
    chk("drain1_meta", out_meta, 64'h22);
    chk("drain1_count", 64'(count), 64'd1);
    step();
    chk("drain2_valid", 64'(out_valid), 64'd0);
    chk("drain2_count", 64'(count), 64'd0);
    chk("drain2_pc", 64'(out_pc), 64'd0);

    // Streaming at full throughput.
    out_ready = 1; in_valid = 1;
    for (int k = 0; k < 10; k++) begin
      in_pc = 32'hBFC0_0000 + 32'(4 * k);
      step();
      chk("stream_pc", 64'(out_pc), 64'(32'hBFC0_0000 + 32'(4 * k)));
      chk("stream_pc_8", 64'(out_pc_8), 64'(32'hBFC0_0008 + 32'(4 * k)));
      chk("stream_count", 64'(count), 64'd1);
    end
    in_valid = 0;
    step();
    chk("stream_end_count", 64'(count), 64'd0);

    // pc+8 wrap and flag carriage.
    out_ready = 0; in_valid = 1; in_pc = 32'hFFFF_FFFC; in_bd = 1; in_ae = 1;
    in_meta = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    in_valid = 0; in_bd = 0; in_ae = 0; in_meta = 0;
    chk("wrap_pc", 64'(out_pc), 64'hFFFF_FFFC);
    chk("wrap_pc_8", 64'(out_pc_8), 64'h0000_0004);
    chk("wrap_bd", 64'(out_bd), 64'd1);
    chk("wrap_ae", 64'(out_ae), 64'd1);
    chk("wrap_meta", out_meta, 64'hFFFF_FFFF_FFFF_FFFF);

    // Flush colliding with push and pop.
    flush = 1; in_valid = 1; in_pc = 32'h2000; out_ready = 1;
    step();
    flush = 0; in_valid = 0;
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    step();
    chk("flush_after_count", 64'(count), 64'd0);
    chk("flush_after_valid", 64'(out_valid), 64'd0);
    out_ready = 0; in_valid = 1; in_pc = 32'h3000;
    step();
    chk("post_flush_pc", 64'(out_pc), 64'h3000);
    in_pc = 32'h3004;
    step();
    in_valid = 0;
    chk("pre_rst_count", 64'(count), 64'd2);

    // Asynchronous reset mid-cycle.
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    chk("arst_out_pc", 64'(out_pc), 64'd0);
    step();
    resetn = 1'b1;
    step();

    // DEPTH=4 pointer wrap with irregular out_ready.
    ptn = 64'hFFFF_FFFF_F5A3_9C00;
    n_pushed = 0;
    max_cnt = 0;
    chk("d4_init_count", 64'(count4), 64'd0);
    for (int cyc = 0; cyc < 64; cyc++) begin
      if (n_pushed == 9 && q.size() == 0) break;
      in_valid4 = (n_pushed < 9);
      pc_now = 32'h100 * 32'(n_pushed + 1);
      in_pc4 = pc_now;
      in_meta4 = 8'(n_pushed);
      out_ready4 = ptn[cyc];
      exp_push = in_valid4 && (q.size() < 4);
      exp_pop  = (q.size() > 0) && out_ready4;
      step();
      if (exp_pop) void'(q.pop_front());
      if (exp_push) begin
        q.push_back(pc_now);
        n_pushed++;
      end
      if (q.size() > max_cnt) max_cnt = q.size();
      chk("d4_count", 64'(count4), 64'(q.size()));
      chk("d4_in_ready", 64'(in_ready4), 64'(q.size() != 4));
      chk("d4_out_valid", 64'(out_valid4), 64'(q.size() != 0));
      chk("d4_out_pc", 64'(out_pc4), (q.size() != 0) ? 64'(q[0]) : 64'd0);
      chk("d4_out_pc_8", 64'(out_pc_84), (q.size() != 0) ? 64'(q[0] + 32'd8) : 64'd0);
    end
    in_valid4 = 0;
    chk("d4_done", 64'((n_pushed == 9) && (q.size() == 0)), 64'd1);
    chk("d4_reached_full", 64'(max_cnt), 64'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/if_pd_fifo.md
# if_pd_fifo

Parametrised IF→PD decoupling segment that replaces a single stall/refresh pipeline register with a DEPTH-entry FIFO and a valid/ready handshake on both sides. Each entry holds a fetch PC, precomputed PC+8, the branch-delay-slot flag, the fetch address-error flag and an opaque predictor metadata vector (BTB hit/target/index, gshare take/index, packed by the instantiator). The block sits between the fetch stage and predecode. It absorbs predecode back-pressure without stalling fetch until DEPTH entries are outstanding. A synchronous flush empties it on redirect or exception.

## Interface
Parameters:
- DEPTH, 2, number of entries; power of two, ≥2.
- META_W, 64, width of the predictor metadata vector; ≥1.
- Local: PTR_W = log2(DEPTH); CNT_W = log2(DEPTH)+1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous flush (refresh); empties the FIFO.
- in_valid  in  1  fetch presents an entry.
- in_ready  out  1  FIFO can accept an entry.
- in_pc  in  32  fetch PC.
- in_bd  in  1  entry is a branch delay slot.
- in_addr_error  in  1  fetch address error.
- in_meta  in  META_W  predictor metadata.
- out_valid  out  1  head entry valid.
- out_ready  in  1  predecode accepts the head entry.
- out_pc  out  32  head PC.
- out_pc_8  out  32  head PC+8.
- out_bd  out  1  head delay-slot flag.
- out_addr_error  out  1  head address-error flag.
- out_meta  out  META_W  head metadata.
- count  out  CNT_W  number of occupied entries, 0..DEPTH.

## Operation
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = (count != DEPTH). It depends only on registered state, never on out_ready or in_valid.
- out_valid = (count != 0).
- Storage is a DEPTH-entry register array {pc, pc_8, bd, addr_error, meta} with wr_ptr/rd_ptr of PTR_W bits. Pointers wrap modulo DEPTH.
- On push: write the entry at wr_ptr, with pc_8 = in_pc + 8 computed modulo 2^32 (0xFFFFFFFC → 0x00000004). Then wr_ptr++.
- On pop: rd_ptr++.
- count updates by +1 on push only, -1 on pop only, and stays unchanged on push & pop.
- Outputs show the entry at rd_ptr. When out_valid=0, out_pc, out_pc_8, out_bd, out_addr_error and out_meta are forced to 0.
- flush=1: on the next edge, count=0 and wr_ptr=rd_ptr=0. Any push or pop in that cycle is discarded (flush wins). Storage contents are not cleared.
- Fields are carried unmodified. An entry with addr_error=1 is queued and delivered like any other.
- Reset (resetn=0, asynchronous): count=0, wr_ptr=rd_ptr=0, all storage entries 0. Hence out_valid=0, in_ready=1, all payload outputs 0. Reset mid-operation discards every entry immediately, without waiting for a clock edge.

## Timing
- Push-to-visible latency is 1 cycle: an entry pushed at edge N appears on the outputs after edge N (out_valid=1 in cycle N+1). There is no combinational in→out bypass.
- Full throughput: with out_ready held at 1 and count<DEPTH, one push and one pop per cycle; count stays constant.
- When full (count=DEPTH), in_ready=0 even if out_ready=1 in the same cycle. There is no full-through, so the in_ready path stays registered.
- When empty, out_valid=0 and a pop is impossible. A push when empty does not reach the outputs until the following cycle.
- After flush is deasserted, the first push can occur in the cycle immediately after the flush edge (in_ready=1).
- Back-pressure: while out_ready=0, the head entry and its outputs stay stable, and out_valid stays 1.

## Test plan
- Reset: assert resetn=0 mid-cycle with count=2 → out_valid=0, in_ready=1, count=0 and out_pc=0 immediately, without waiting for clk.
- Fill/drain with DEPTH=2 and out_ready=0: push PCs 0x1000, 0x1004 → count=2, in_ready=0; a push of 0x1008 is not accepted. Then set out_ready=1 → pops 0x1000, then 0x1004, each out_pc_8=PC+8, then out_valid=0.
- Streaming: in_valid=out_ready=1 for 10 cycles with PCs 0xBFC00000+4k → outputs match in order with 1-cycle latency; count stays 1.
- Wrap/pc_8: push in_pc=0xFFFFFFFC, in_bd=1, in_addr_error=1, meta=all-ones → out_pc_8=0x00000004, out_bd=1, out_addr_error=1, out_meta=all-ones.
- Flush collision: count=1 and flush=1 with push and pop both true → next cycle count=0, out_valid=0; the pushed entry never appears.
- Pointer wrap with DEPTH=4: 9 pushes interleaved with random out_ready → in-order delivery, count never exceeds 4, and in_ready=0 exactly when count=4.
